// File: rtl/openila_pkg.sv
`default_nettype none
// ============================================================================
// Module      : openila_pkg
// Description : Shared state encodings and default widths for the capture core.
// Revision    : 1.0 - initial release
// ============================================================================
package openila_pkg;

    localparam int c_W_DATA_DEFAULT = 8;
    localparam int c_W_ADDR_DEFAULT = 6;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_PRETRIG   = 3'd1;
    localparam logic [2:0] c_WAIT_TRIG = 3'd2;
    localparam logic [2:0] c_POSTTRIG  = 3'd3;
    localparam logic [2:0] c_DONE      = 3'd4;

endpackage
`default_nettype wire

// File: rtl/openila_capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : openila_capture_ram
// Description : Simple dual-port sample buffer, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module openila_capture_ram #(
    parameter int W_DATA = 8,
    parameter int W_ADDR = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [W_ADDR-1:0] waddr,
    input  logic [W_DATA-1:0] wdata,
    input  logic              re,
    input  logic [W_ADDR-1:0] raddr,
    output logic [W_DATA-1:0] rdata
);

    logic [W_DATA-1:0] r_mem [2**W_ADDR];
    logic [W_DATA-1:0] r_q;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_q <= r_mem[raddr];
        end
    end

    assign rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/openila_capture.sv
`default_nettype none
// ============================================================================
// Module      : openila_capture
// Description : Logic-analyser capture FSM with pre/post-trigger window and readout.
// Revision    : 1.0 - initial release
// ============================================================================
module openila_capture
    import openila_pkg::*;
#(
    parameter int W_DATA = c_W_DATA_DEFAULT,
    parameter int W_ADDR = c_W_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DATA-1:0] sample,
    input  logic              trigger,
    input  logic              arm,
    input  logic              disarm,
    input  logic [W_ADDR-1:0] pretrig_count,
    output logic [2:0]        state_out,
    output logic              done,
    input  logic              rd_en,
    output logic [W_DATA-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last
);

    localparam int c_D = 2**W_ADDR;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [W_ADDR-1:0] r_wr_ptr;
    logic [W_ADDR-1:0] r_rd_ptr;
    logic [W_ADDR-1:0] r_pre_len;
    logic [W_ADDR-1:0] r_pre_cnt;
    logic [W_ADDR:0]   r_post_cnt;
    logic [W_ADDR-1:0] r_rd_cnt;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic [W_ADDR:0]   w_post_len;
    logic              w_we;
    logic              w_rd_acc;
    logic [W_DATA-1:0] w_ram_q;

    // Post-trigger length ranges 1..D, so it needs one bit more than a pointer.
    assign w_post_len = (W_ADDR+1)'(c_D) - {1'b0, r_pre_len};

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_rd_acc    = 1'b0;
        case (r_state)
            c_IDLE: begin
            end
            c_PRETRIG: begin
                w_we = 1'b1;
                if (r_pre_cnt == r_pre_len - W_ADDR'(1)) begin
                    w_state_nxt = c_WAIT_TRIG;
                end
            end
            c_WAIT_TRIG: begin
                w_we = 1'b1;
                if (trigger) begin
                    w_state_nxt = (w_post_len == (W_ADDR+1)'(1)) ? c_DONE : c_POSTTRIG;
                end
            end
            c_POSTTRIG: begin
                w_we = 1'b1;
                if (r_post_cnt + (W_ADDR+1)'(1) == w_post_len) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_rd_acc = rd_en;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
        if (arm) begin
            w_state_nxt = (pretrig_count == '0) ? c_WAIT_TRIG : c_PRETRIG;
            w_we        = 1'b0;
            w_rd_acc    = 1'b0;
        end
        if (disarm) begin
            w_state_nxt = c_IDLE;
            w_we        = 1'b0;
            w_rd_acc    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pre_len  <= '0;
            r_pre_cnt  <= '0;
            r_post_cnt <= '0;
            r_rd_cnt   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_valid <= w_rd_acc;
            r_rd_last  <= w_rd_acc && (r_rd_cnt == '1);
            if (!disarm && arm) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_pre_cnt  <= '0;
                r_post_cnt <= '0;
                r_rd_cnt   <= '0;
                r_pre_len  <= pretrig_count;
            end else if (!disarm) begin
                if (w_we) begin
                    r_wr_ptr <= r_wr_ptr + W_ADDR'(1);
                end
                if (r_state == c_PRETRIG) begin
                    r_pre_cnt <= r_pre_cnt + W_ADDR'(1);
                end
                if (r_state == c_WAIT_TRIG && trigger) begin
                    r_post_cnt <= (W_ADDR+1)'(1);
                end
                if (r_state == c_POSTTRIG) begin
                    r_post_cnt <= r_post_cnt + (W_ADDR+1)'(1);
                end
                // The final write lands this cycle, so the oldest sample sits one past it.
                if (r_state != c_DONE && w_state_nxt == c_DONE) begin
                    r_rd_ptr <= r_wr_ptr + W_ADDR'(1);
                    r_rd_cnt <= '0;
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + W_ADDR'(1);
                    r_rd_cnt <= r_rd_cnt + W_ADDR'(1);
                end
            end
        end
    end

    openila_capture_ram #(
        .W_DATA (W_DATA),
        .W_ADDR (W_ADDR)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (sample),
        .re    (w_rd_acc),
        .raddr (r_rd_ptr),
        .rdata (w_ram_q)
    );

    assign state_out = r_state;
    assign done      = (r_state == c_DONE);
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    // The RAM output register has no reset; masking keeps rd_data at 0 when idle.
    assign rd_data   = r_rd_valid ? w_ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_openila_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_openila_capture
// Description : Self-checking bench for openila_capture with a readout scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_openila_capture;

    localparam int c_W_DATA = 8;
    localparam int c_W_ADDR = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [c_W_DATA-1:0] sample = '0;
    logic                trigger = 1'b0;
    logic                arm = 1'b0;
    logic                disarm = 1'b0;
    logic [c_W_ADDR-1:0] pretrig_count = '0;
    logic [2:0]          state_out;
    logic                done;
    logic                rd_en = 1'b0;
    logic [c_W_DATA-1:0] rd_data;
    logic                rd_valid;
    logic                rd_last;

    int n_chk = 0;
    int n_err = 0;
    logic [c_W_DATA:0] sb_q[$];

    openila_capture #(
        .W_DATA (c_W_DATA),
        .W_ADDR (c_W_ADDR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample        (sample),
        .trigger       (trigger),
        .arm           (arm),
        .disarm        (disarm),
        .pretrig_count (pretrig_count),
        .state_out     (state_out),
        .done          (done),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_last       (rd_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every delivered word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (sb_q.size() == 0) begin
                check("rd_spurious", 32'(rd_valid), 32'd0);
            end else begin
                logic [c_W_DATA:0] e;
                e = sb_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e[c_W_DATA-1:0]));
                check("rd_last", 32'(rd_last), 32'(e[c_W_DATA]));
            end
        end
    end

    task automatic do_arm(input int pre);
        arm = 1'b1;
        pretrig_count = c_W_ADDR'(pre);
        tick;
        arm = 1'b0;
    endtask

    // Sample value equals the write index since arm; bounded loop ends on done.
    task automatic capture(input int pre, input int t1, input int t2, output int last);
        int v;
        do_arm(pre);
        check("arm_state", 32'(state_out), (pre == 0) ? 32'd2 : 32'd1);
        v = 0;
        while (!done && v < 100) begin
            sample  = c_W_DATA'(v);
            trigger = (v == t1) || (v == t2);
            tick;
            v++;
        end
        trigger = 1'b0;
        last = v - 1;
        check("cap_done", 32'(done), 32'd1);
        check("cap_state", 32'(state_out), 32'd4);
    endtask

    task automatic read_pass(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            sb_q.push_back({((i % 16) == 15), c_W_DATA'(first + (i % 16))});
            tick;
        end
        rd_en = 1'b0;
        tick;
    endtask

    initial begin
        int last;
        // Reset state
        tick;
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_last", 32'(rd_last), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        tick;

        // Pretrigger 4, trigger at sample 9, one extra read to see the wrap
        capture(4, 9, -1, last);
        check("t1_last_wr", 32'(last), 32'd20);
        read_pass(17, 5);

        // No pretrigger, trigger on first sample
        capture(0, 0, -1, last);
        check("t2_last_wr", 32'(last), 32'd15);
        read_pass(16, 0);

        // Maximum pretrigger; trigger inside PRETRIG is ignored
        capture(15, 7, 30, last);
        check("t3_last_wr", 32'(last), 32'd30);
        read_pass(16, 15);

        // Disarm in WAIT_TRIG
        do_arm(2);
        for (int i = 0; i < 5; i++) begin
            sample = c_W_DATA'(i);
            tick;
        end
        check("t4_wait", 32'(state_out), 32'd2);
        disarm = 1'b1;
        tick;
        disarm = 1'b0;
        check("t4_idle", 32'(state_out), 32'd0);
        trigger = 1'b1;
        tick;
        trigger = 1'b0;
        check("t4_trig_idle", 32'(state_out), 32'd0);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("t4_rd_ignored", 32'(rd_valid), 32'd0);

        // rd_en during capture, then arm+disarm coincide
        do_arm(3);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("t5_rd_capture", 32'(rd_valid), 32'd0);
        check("t5_pretrig", 32'(state_out), 32'd1);
        arm = 1'b1;
        disarm = 1'b1;
        tick;
        arm = 1'b0;
        disarm = 1'b0;
        check("t5_idle", 32'(state_out), 32'd0);

        // Reset mid-readout, then a fresh capture
        capture(4, 9, -1, last);
        read_pass(5, 5);
        @(negedge clk);
        rd_en = 1'b1;
        rst = 1'b1;
        #1;
        check("t6_state", 32'(state_out), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_valid", 32'(rd_valid), 32'd0);
        check("t6_data", 32'(rd_data), 32'd0);
        tick;
        tick;
        check("t6_valid_hold", 32'(rd_valid), 32'd0);
        rd_en = 1'b0;
        rst = 1'b0;
        tick;
        capture(4, 9, -1, last);
        check("t6_last_wr", 32'(last), 32'd20);
        read_pass(16, 5);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/openila_capture.md
OPENILA_CAPTURE -- requirements
Module: openila_capture

Interface
REQ-001 SHALL have parameter W_DATA, default 8: sample width in bits.
REQ-002 SHALL have parameter W_ADDR, default 6: log2 of buffer depth; D = 2^W_ADDR.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sample  input  W_DATA  probe data, captured every clock while capturing.
REQ-006 SHALL have port trigger  input  1  trigger-unit output, aligned to the same-cycle sample.
REQ-007 SHALL have port arm  input  1  one-cycle pulse: start a new capture.
REQ-008 SHALL have port disarm  input  1  one-cycle pulse: abort to IDLE.
REQ-009 SHALL have port pretrig_count  input  W_ADDR  samples to keep before the trigger; latched on arm.
REQ-010 SHALL have port state_out  output  3  current state encoding.
REQ-011 SHALL have port done  output  1  high while in DONE.
REQ-012 SHALL have port rd_en  input  1  readout request, honoured only in DONE.
REQ-013 SHALL have port rd_data  output  W_DATA  readout word.
REQ-014 SHALL have port rd_valid  output  1  rd_data valid, exactly one cycle after an accepted rd_en.
REQ-015 SHALL have port rd_last  output  1  qualifies rd_valid: the word is the newest (D-th) sample.

Function
REQ-016 SHALL implement states IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE.
REQ-017 IDLE: no writes; arm -> PRETRIG; if the latched pretrig_count is 0 -> WAIT_TRIG.
REQ-018 PRETRIG: write sample each cycle at wr_ptr, wr_ptr++ (mod D); trigger ignored; -> WAIT_TRIG once pretrig_count samples are written.
REQ-019 WAIT_TRIG: keep writing circularly; trigger high -> POSTTRIG; that cycle's sample is stored as post-trigger sample 1.
REQ-020 POSTTRIG: write until D - pretrig_count post-trigger samples, including the trigger sample, are stored; then -> DONE with no further writes.
REQ-021 On entry to DONE, rd_ptr SHALL equal the final wr_ptr, the oldest sample in the window.
REQ-022 DONE: each rd_en returns mem[rd_ptr] on rd_data the next cycle with rd_valid=1, then rd_ptr++ (mod D).
REQ-023 rd_last SHALL assert on the D-th read of each pass; the next rd_en wraps to the oldest sample again.
REQ-024 rd_en outside DONE SHALL be ignored: rd_valid stays 0.
REQ-025 arm in any state SHALL restart the capture: wr_ptr=0, counters cleared, pretrig_count relatched.
REQ-026 disarm in any state SHALL go to IDLE the next cycle; if arm and disarm coincide, disarm wins.
REQ-027 A pretrig_count of D-1 is legal (one post-trigger sample); counters SHALL wrap only modulo D.
REQ-028 A trigger that coincides with the last PRETRIG write SHALL be ignored.
REQ-029 state_out encoding: IDLE=0, PRETRIG=1, WAIT_TRIG=2, POSTTRIG=3, DONE=4.

Reset
REQ-030 While rst is high: state IDLE, wr_ptr=0, rd_ptr=0, all counters 0, done=0, rd_valid=0, rd_last=0, rd_data=0.
REQ-031 Buffer contents SHALL NOT be reset.
REQ-032 Reset mid-capture or mid-readout SHALL abandon the operation with no spurious rd_valid.

Structure
REQ-033 State encodings and the W_DATA/W_ADDR defaults SHALL live in shared package openila_pkg.
REQ-034 Storage SHALL be the sub-module openila_capture_ram: simple dual-port, synchronous write, registered read, D x W_DATA, no reset.
REQ-035 The FSM, pointers and counters SHALL be in openila_capture; no other sub-modules.

Verification (bench: W_ADDR=4, D=16, sample = cycle count)
REQ-036 pretrig_count=4, trigger on the 10th sample (value 9) -> DONE after 12 post-trigger writes; 16 reads return 5..20; rd_last on 20.
REQ-037 pretrig_count=0, trigger on the first cycle after arm (sample 0) -> reads return 0..15.
REQ-038 pretrig_count=15, trigger during PRETRIG at sample 7 -> ignored; next trigger at sample 30 -> reads return 15..30.
REQ-039 disarm in WAIT_TRIG -> IDLE next cycle; a later trigger has no effect; rd_en gives rd_valid=0.
REQ-040 Arm and disarm in the same cycle -> IDLE; rd_en during capture -> no rd_valid.
REQ-041 rst pulsed after the 5th read in DONE -> all outputs 0 and IDLE; re-arm -> correct fresh capture.
